core_input_arbiter: RTL and testbench

- Shares the single ADC sample stream among the multicore's processing cores. Each core raises a request when it executes an input instruction.
- Samples from the source are buffered in a small FIFO.
- One pending requester per cycle is granted, round-robin. It receives the next sample on a broadcast data bus together with a one-hot grant.
- Sits between the sample source (ADC or file reader in simulation) and the `multicore` input port. It replaces the shared-`in` / OR-of-requests scheme.

---
 rtl/core_input_arbiter.sv | 87 ++++++++
 tb/tb_core_input_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/core_input_arbiter.sv
// Round-robin input arbiter: buffers source samples in a FIFO and hands one
// sample per cycle to a requesting core, with a one-hot grant on a broadcast bus.
module core_input_arbiter #(
  parameter int NCORES     = 26,
  parameter int DW         = 31,
  parameter int FIFO_DEPTH = 8,
  parameter int UW         = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [DW-1:0]          src_data,
  input  logic                          src_valid,
  output logic                          src_ready,
  input  logic [NCORES-1:0]             req,
  output logic signed [DW-1:0]          core_data,
  output logic [NCORES-1:0]             grant,
  output logic                          grant_valid,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic [UW-1:0]                 underrun_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = $clog2(NCORES);

  logic signed [DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        win_idx;
  logic [NCORES-1:0]    elig;
  logic [31:0]          cand;
  logic                 win_found;
  logic                 push;
  logic                 pop;

  assign src_ready   = (level != LW'(FIFO_DEPTH));
  assign push        = src_valid && src_ready;
  // Last cycle's grant masks its core, covering the one-cycle req release lag.
  assign elig        = req & ~grant;
  assign pop         = (level != '0) && win_found;
  assign grant_valid = |grant;

  // First eligible core searching upward from the core after the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned off = 1; off <= NCORES; off++) begin
      cand = (32'(rr_ptr) + off) % NCORES;
      if (!win_found && elig[cand[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= src_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      grant        <= '0;
      core_data    <= '0;
      rr_ptr       <= PW'(NCORES - 1);
      underrun_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        grant     <= {{(NCORES-1){1'b0}}, 1'b1} << win_idx;
        core_data <= mem[rd_ptr];
        rr_ptr    <= win_idx;
      end else begin
        grant <= '0;
      end
      level <= level + LW'(push) - LW'(pop);
      if (req != '0 && level == '0 && underrun_cnt != '1)
        underrun_cnt <= underrun_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_core_input_arbiter.sv
// Directed self-checking bench for core_input_arbiter.
module tb_core_input_arbiter;

  localparam int NC = 26;
  localparam int DW = 31;
  localparam int FD = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] src_data;
  logic                 src_valid;
  logic                 src_ready;
  logic [NC-1:0]        req;
  logic signed [DW-1:0] core_data;
  logic [NC-1:0]        grant;
  logic                 grant_valid;
  logic [3:0]           level;
  logic [15:0]          underrun_cnt;

  logic                 u4_src_ready;
  logic signed [DW-1:0] u4_core_data;
  logic [NC-1:0]        u4_grant;
  logic                 u4_grant_valid;
  logic [3:0]           u4_level;
  logic [3:0]           u4_underrun_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  core_input_arbiter #(.NCORES(NC), .DW(DW), .FIFO_DEPTH(FD), .UW(16)) dut (
    .clk(clk), .rst(rst), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .req(req), .core_data(core_data), .grant(grant),
    .grant_valid(grant_valid), .level(level), .underrun_cnt(underrun_cnt)
  );

  core_input_arbiter #(.NCORES(NC), .DW(DW), .FIFO_DEPTH(FD), .UW(4)) dut_u4 (
    .clk(clk), .rst(rst), .src_data(src_data), .src_valid(src_valid),
    .src_ready(u4_src_ready), .req(req), .core_data(u4_core_data), .grant(u4_grant),
    .grant_valid(u4_grant_valid), .level(u4_level), .underrun_cnt(u4_underrun_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; src_valid = 1'b0; src_data = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (core_data !== '0) begin errors++; $display("FAIL reset_core_data got %0d exp 0", core_data); end
    checks++; if (grant !== '0) begin errors++; $display("FAIL reset_grant got %h exp 0", grant); end
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_grant_valid got %b exp 0", grant_valid); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL reset_underrun got %0d exp 0", underrun_cnt); end
    checks++; if (src_ready !== 1'b1) begin errors++; $display("FAIL reset_src_ready got %b exp 1", src_ready); end
  endtask

  task automatic test_single_latency();
    logic signed [DW-1:0] exp_d;
    do_reset();
    exp_d = -5;
    src_data = exp_d; src_valid = 1'b1; req = NC'(1) << 3;
    step();
    src_valid = 1'b0;
    checks++; if (level !== 4'd1) begin errors++; $display("FAIL lat_level_after_push got %0d exp 1", level); end
    checks++; if (grant !== '0) begin errors++; $display("FAIL lat_no_bypass got %h exp 0", grant); end
    step();
    checks++; if (grant !== 26'h0000008) begin errors++; $display("FAIL lat_grant got %h exp 0000008", grant); end
    checks++; if (grant_valid !== 1'b1) begin errors++; $display("FAIL lat_grant_valid got %b exp 1", grant_valid); end
    checks++; if (core_data !== exp_d) begin errors++; $display("FAIL lat_data got %0d exp -5", core_data); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL lat_level_after_pop got %0d exp 0", level); end
    req = '0;
    step();
    checks++; if (grant !== '0) begin errors++; $display("FAIL lat_no_regrant got %h exp 0", grant); end
  endtask

  task automatic test_round_robin();
    int cores [3];
    int age [3];
    int order [8];
    int ngrants;
    logic [NC-1:0] exp_g;
    cores = '{0, 5, 25};
    order = '{0, 5, 25, 0, 5, 25, 0, 5};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      src_data = DW'(i + 1); src_valid = 1'b1;
      step();
    end
    src_valid = 1'b0;
    checks++; if (src_ready !== 1'b0) begin errors++; $display("FAIL rr_preload_full got %b exp 0", src_ready); end
    age = '{0, 0, 0};
    req = (NC'(1) << 0) | (NC'(1) << 5) | (NC'(1) << 25);
    ngrants = 0;
    for (int c = 0; c < 11; c++) begin
      step();
      if (grant_valid === 1'b1) ngrants++;
      if (c < 8) begin
        exp_g = NC'(1) << order[c];
        checks++; if (grant !== exp_g) begin errors++; $display("FAIL rr_grant[%0d] got %h exp %h", c, grant, exp_g); end
        checks++; if (core_data !== DW'(c + 1)) begin errors++; $display("FAIL rr_data[%0d] got %0d exp %0d", c, core_data, c + 1); end
      end
      req = '0;
      for (int k = 0; k < 3; k++) begin
        if (age[k] == 1) age[k] = 2;
        else if (age[k] == 2) age[k] = 0;
        if (grant[cores[k]] === 1'b1) age[k] = 1;
        if (age[k] != 2) req[cores[k]] = 1'b1;
      end
    end
    req = '0;
    checks++; if (ngrants != 8) begin errors++; $display("FAIL rr_grant_count got %0d exp 8", ngrants); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL rr_level_end got %0d exp 0", level); end
  endtask

  task automatic test_back_pressure();
    int nxt;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      src_data = DW'(101 + i); src_valid = 1'b1;
      step();
    end
    checks++; if (src_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b exp 0", src_ready); end
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL bp_full_level got %0d exp 8", level); end
    src_data = DW'(109);
    step();
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL bp_held_level got %0d exp 8", level); end
    req = NC'(1) << 1;
    step();
    checks++; if (grant !== (NC'(1) << 1)) begin errors++; $display("FAIL bp_grant got %h exp 0000002", grant); end
    checks++; if (core_data !== DW'(101)) begin errors++; $display("FAIL bp_data got %0d exp 101", core_data); end
    checks++; if (level !== 4'd7) begin errors++; $display("FAIL bp_level_pop got %0d exp 7", level); end
    checks++; if (src_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %b exp 1", src_ready); end
    req = '0;
    step();
    src_valid = 1'b0;
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL bp_ninth_accepted got %0d exp 8", level); end
    req = NC'(1) << 1;
    nxt = 102;
    for (int c = 0; c < 20; c++) begin
      step();
      if (grant_valid === 1'b1) begin
        checks++; if (core_data !== DW'(nxt)) begin errors++; $display("FAIL bp_drain_data got %0d exp %0d", core_data, nxt); end
        nxt++;
      end
    end
    req = '0;
    checks++; if (nxt != 110) begin errors++; $display("FAIL bp_drain_count got %0d exp 110", nxt); end
  endtask

  task automatic test_underrun();
    int ng;
    do_reset();
    req = '1;
    ng = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (grant_valid !== 1'b0) ng++;
    end
    checks++; if (underrun_cnt !== 16'd10) begin errors++; $display("FAIL ur_count10 got %0d exp 10", underrun_cnt); end
    checks++; if (u4_underrun_cnt !== 4'd10) begin errors++; $display("FAIL ur_u4_count10 got %0d exp 10", u4_underrun_cnt); end
    for (int c = 0; c < 10; c++) begin
      step();
      if (grant_valid !== 1'b0) ng++;
    end
    checks++; if (underrun_cnt !== 16'd20) begin errors++; $display("FAIL ur_count20 got %0d exp 20", underrun_cnt); end
    checks++; if (u4_underrun_cnt !== 4'd15) begin errors++; $display("FAIL ur_u4_saturate got %0d exp 15", u4_underrun_cnt); end
    checks++; if (ng != 0) begin errors++; $display("FAIL ur_no_grants got %0d exp 0", ng); end
    req = '0;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    src_data = DW'(11); src_valid = 1'b1; step();
    src_data = DW'(12); step();
    src_valid = 1'b0;
    req = NC'(1) << 1;
    step();
    checks++; if (grant !== (NC'(1) << 1)) begin errors++; $display("FAIL mid_pre_grant got %h exp 0000002", grant); end
    req = NC'(1) << 2;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (grant !== '0) begin errors++; $display("FAIL mid_grant_suppressed got %h exp 0", grant); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL mid_level got %0d exp 0", level); end
    checks++; if (core_data !== '0) begin errors++; $display("FAIL mid_core_data got %0d exp 0", core_data); end
    req = (NC'(1) << 0) | (NC'(1) << 2);
    src_data = DW'(13); src_valid = 1'b1;
    step();
    src_valid = 1'b0;
    checks++; if (grant !== '0) begin errors++; $display("FAIL mid_push_no_grant got %h exp 0", grant); end
    step();
    checks++; if (grant !== (NC'(1) << 0)) begin errors++; $display("FAIL mid_ptr_restart got %h exp 0000001", grant); end
    checks++; if (core_data !== DW'(13)) begin errors++; $display("FAIL mid_data got %0d exp 13", core_data); end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_round_robin();
    test_back_pressure();
    test_underrun();
    test_reset_mid_grant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
